// File: rtl/mc_control.sv
// mc_control: multi-cycle IF/ID/EX/MEM/WB sequencer for the miniRV datapath.
// Latency: B 3, R/I/LUI/JAL/JALR/S 4, LOAD 5 cycles; each memory wait cycle adds 1.
// Backpressure: imem_req/dmem_req stay high until ready; all strobes drop in reset.
// Optional build macro MC_ILLEGAL_TRAP_EN: unknown opcodes and bad branch funct3 trap to HALT.
module mc_control #(
    parameter int CNT_W       = 32,
    parameter int RST_PC_HOLD = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dram_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic [1:0]       npc_op,
    output logic [1:0]       rf_wsel,
    output logic [2:0]       sext_op,
    output logic             alub_sel,
    output logic [3:0]       alu_op,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] inst_cnt
);

    // Opcodes of the miniRV subset
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Next-PC select
    localparam logic [1:0] C_NPC_PC4  = 2'd0;
    localparam logic [1:0] C_NPC_B    = 2'd1;
    localparam logic [1:0] C_NPC_JAL  = 2'd2;
    localparam logic [1:0] C_NPC_JALR = 2'd3;

    // Write-back select
    localparam logic [1:0] S_ALU  = 2'd0;
    localparam logic [1:0] S_DRAM = 2'd1;
    localparam logic [1:0] S_PC4  = 2'd2;
    localparam logic [1:0] S_IMM  = 2'd3;

    // Immediate format select
    localparam logic [2:0] SEXT_NONE  = 3'd0;
    localparam logic [2:0] SEXT_I     = 3'd1;
    localparam logic [2:0] SEXT_SHIFT = 3'd2;
    localparam logic [2:0] SEXT_S     = 3'd3;
    localparam logic [2:0] SEXT_B     = 3'd4;
    localparam logic [2:0] SEXT_U     = 3'd5;
    localparam logic [2:0] SEXT_J     = 3'd6;

    // ALU operations
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_BEQ = 4'd8;
    localparam logic [3:0] ALU_BNE = 4'd9;
    localparam logic [3:0] ALU_BLT = 4'd10;
    localparam logic [3:0] ALU_BGE = 4'd11;

    localparam logic [1:0] HOLD_INIT = 2'(RST_PC_HOLD);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] hold_cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7_alt;
    logic       is_r, is_i, is_load, is_jalr, is_s, is_b, is_lui, is_jal;
    logic       is_known, b_f3_ok;
    logic       unused_inst;

    // Raw (pre-reset-gating) strobes from the FSM
    logic       imem_req_r, ir_we_r, dmem_req_r, dram_we_r, pc_we_r, rf_we_r;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign f7_alt      = inst[30];
    assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

    assign is_r     = (opcode == OP_R);
    assign is_i     = (opcode == OP_I);
    assign is_load  = (opcode == OP_LOAD);
    assign is_jalr  = (opcode == OP_JALR);
    assign is_s     = (opcode == OP_S);
    assign is_b     = (opcode == OP_B);
    assign is_lui   = (opcode == OP_LUI);
    assign is_jal   = (opcode == OP_JAL);
    assign is_known = is_r | is_i | is_load | is_jalr | is_s | is_b | is_lui | is_jal;
    assign b_f3_ok  = (funct3 == 3'b000) | (funct3 == 3'b001) |
                      (funct3 == 3'b100) | (funct3 == 3'b101);

    // State register; reset restarts at a fresh IF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IF;
        end else begin
            state <= state_nxt;
        end
    end

    // Post-reset fetch hold: counts down only while sitting in IF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= HOLD_INIT;
        end else if (state == ST_IF && hold_cnt != 2'd0) begin
            hold_cnt <= hold_cnt - 2'd1;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        state_nxt  = state;
        imem_req_r = 1'b0;
        ir_we_r    = 1'b0;
        dmem_req_r = 1'b0;
        dram_we_r  = 1'b0;
        pc_we_r    = 1'b0;
        rf_we_r    = 1'b0;
        case (state)
            ST_IF: begin
                if (hold_cnt == 2'd0) begin
                    imem_req_r = 1'b1;
                    if (imem_ready) begin
                        ir_we_r   = 1'b1;
                        state_nxt = ST_ID;
                    end
                end
            end
            ST_ID: begin
                state_nxt = ST_EX;
            end
            ST_EX: begin
`ifdef MC_ILLEGAL_TRAP_EN
                if (!is_known || (is_b && !b_f3_ok)) begin
                    state_nxt = ST_HALT;
                end else
`endif
                if (is_b) begin
                    pc_we_r   = 1'b1;
                    state_nxt = ST_IF;
                end else if (is_load || is_s) begin
                    state_nxt = ST_MEM;
                end else begin
                    // R, I, LUI, JAL, JALR and (untrapped) unknown opcodes
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req_r = 1'b1;
                dram_we_r  = is_s;
                if (dmem_ready) begin
                    if (is_s) begin
                        pc_we_r   = 1'b1;
                        state_nxt = ST_IF;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end
            end
            ST_WB: begin
                // Unknown opcodes retire without touching the register file
                rf_we_r   = is_known;
                pc_we_r   = 1'b1;
                state_nxt = ST_IF;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IF;
            end
        endcase
    end

    // Strobes are forced low for as long as reset is held
    assign imem_req = rst_n & imem_req_r;
    assign ir_we    = rst_n & ir_we_r;
    assign dmem_req = rst_n & dmem_req_r;
    assign dram_we  = rst_n & dram_we_r;
    assign pc_we    = rst_n & pc_we_r;
    assign rf_we    = rst_n & rf_we_r;
    assign state_o  = state;

    // Decode fields from the instruction register; zero while in reset
    always_comb begin
        npc_op   = C_NPC_PC4;
        rf_wsel  = S_ALU;
        sext_op  = SEXT_NONE;
        alub_sel = 1'b0;
        alu_op   = ALU_ADD;
        if (rst_n) begin
            if (is_r || is_i) begin
                case (funct3)
                    3'b000:  alu_op = (is_r && f7_alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = f7_alt ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            if (is_i) begin
                alub_sel = 1'b1;
                sext_op  = (funct3 == 3'b001 || funct3 == 3'b101) ? SEXT_SHIFT : SEXT_I;
            end
            if (is_load) begin
                alub_sel = 1'b1;
                sext_op  = SEXT_I;
                rf_wsel  = S_DRAM;
            end
            if (is_jalr) begin
                alub_sel = 1'b1;
                sext_op  = SEXT_I;
                rf_wsel  = S_PC4;
                npc_op   = C_NPC_JALR;
            end
            if (is_s) begin
                alub_sel = 1'b1;
                sext_op  = SEXT_S;
            end
            if (is_b) begin
                sext_op = SEXT_B;
                npc_op  = C_NPC_B;
                case (funct3)
                    3'b001:  alu_op = ALU_BNE;
                    3'b100:  alu_op = ALU_BLT;
                    3'b101:  alu_op = ALU_BGE;
                    default: alu_op = ALU_BEQ;
                endcase
            end
            if (is_lui) begin
                sext_op = SEXT_U;
                rf_wsel = S_IMM;
            end
            if (is_jal) begin
                sext_op = SEXT_J;
                rf_wsel = S_PC4;
                npc_op  = C_NPC_JAL;
            end
        end
    end

    // Retired-instruction counter: every retirement commits the PC exactly once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_cnt <= '0;
        end else if (pc_we) begin
            inst_cnt <= inst_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed bench for the mc_control sequencer.
// Latency: checks every cycle of each instruction against hand-computed values.
// Backpressure: holds dmem_ready low to stretch MEM and pulses reset mid-access.
module tb_mc_control;

    localparam logic [31:0] I_SUB = 32'h402081B3;  // sub x3,x1,x2
    localparam logic [31:0] I_LW  = 32'h0040A283;  // lw  x5,4(x1)
    localparam logic [31:0] I_SW  = 32'h0050A423;  // sw  x5,8(x1)
    localparam logic [31:0] I_BEQ = 32'h00208063;  // beq x1,x2,0
    localparam logic [31:0] I_BAD = 32'h0000007F;  // unknown opcode

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic        imem_ready, dmem_ready;
    logic        imem_req, ir_we, dmem_req, dram_we, pc_we, rf_we;
    logic [1:0]  npc_op, rf_wsel;
    logic [2:0]  sext_op;
    logic        alub_sel;
    logic [3:0]  alu_op;
    logic [2:0]  state_o;
    logic [31:0] inst_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    mc_control #(.CNT_W(32), .RST_PC_HOLD(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_we      (ir_we),
        .dmem_req   (dmem_req),
        .dram_we    (dram_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .npc_op     (npc_op),
        .rf_wsel    (rf_wsel),
        .sext_op    (sext_op),
        .alub_sel   (alub_sel),
        .alu_op     (alu_op),
        .state_o    (state_o),
        .inst_cnt   (inst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move to the middle of the next cycle (one unit after the falling edge)
    task automatic step;
        @(negedge clk);
        #1;
    endtask

    // Strobe vector {imem_req, ir_we, dmem_req, dram_we, pc_we, rf_we}
    function automatic logic [31:0] strobes();
        return {26'd0, imem_req, ir_we, dmem_req, dram_we, pc_we, rf_we};
    endfunction

    initial begin
        rst_n      = 1'b0;
        inst       = I_SUB;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_strobes", strobes(), 32'h00);
        chk("rst_cnt", inst_cnt, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #1;
        chk("rst_req_gated", strobes(), 32'h00);

        // ---------------- sub, zero-wait ----------------
        rst_n = 1'b1;
        #1;
        chk("sub_hold_c0", strobes(), 32'h00);
        step;
        chk("sub_c1_state", 32'(state_o), 32'd0);
        chk("sub_c1_strobes", strobes(), 32'h30);  // imem_req + ir_we
        step;
        chk("sub_c2_state", 32'(state_o), 32'd1);
        chk("sub_c2_strobes", strobes(), 32'h00);
        chk("sub_alu_op", 32'(alu_op), 32'd1);
        chk("sub_alub", 32'(alub_sel), 32'd0);
        step;
        chk("sub_c3_state", 32'(state_o), 32'd2);
        chk("sub_c3_strobes", strobes(), 32'h00);
        step;
        chk("sub_c4_state", 32'(state_o), 32'd4);
        chk("sub_c4_strobes", strobes(), 32'h03);  // pc_we + rf_we
        chk("sub_rf_wsel", 32'(rf_wsel), 32'd0);
        step;
        chk("sub_done_state", 32'(state_o), 32'd0);
        chk("sub_done_cnt", inst_cnt, 32'd1);

        // ---------------- lw, dmem_ready delayed 3 cycles ----------------
        inst       = I_LW;
        dmem_ready = 1'b0;
        #1;
        chk("lw_c1_strobes", strobes(), 32'h30);
        step;
        chk("lw_c2_state", 32'(state_o), 32'd1);
        chk("lw_rf_wsel", 32'(rf_wsel), 32'd1);
        chk("lw_sext", 32'(sext_op), 32'd1);
        chk("lw_alub", 32'(alub_sel), 32'd1);
        step;
        chk("lw_c3_state", 32'(state_o), 32'd2);
        chk("lw_c3_strobes", strobes(), 32'h00);
        for (int i = 0; i < 3; i++) begin
            step;
            chk("lw_mem_wait_state", 32'(state_o), 32'd3);
            chk("lw_mem_wait_strobes", strobes(), 32'h08);  // dmem_req only
        end
        step;
        dmem_ready = 1'b1;
        #1;
        chk("lw_mem_ready_strobes", strobes(), 32'h08);
        step;
        chk("lw_c8_state", 32'(state_o), 32'd4);
        chk("lw_c8_strobes", strobes(), 32'h03);
        step;
        chk("lw_done_state", 32'(state_o), 32'd0);
        chk("lw_done_cnt", inst_cnt, 32'd2);

        // ---------------- sw, zero-wait ----------------
        inst = I_SW;
        #1;
        chk("sw_c1_strobes", strobes(), 32'h30);
        step;
        chk("sw_c2_strobes", strobes(), 32'h00);
        chk("sw_sext", 32'(sext_op), 32'd3);
        chk("sw_alub", 32'(alub_sel), 32'd1);
        step;
        chk("sw_c3_strobes", strobes(), 32'h00);
        step;
        chk("sw_c4_state", 32'(state_o), 32'd3);
        chk("sw_c4_strobes", strobes(), 32'h0E);  // dmem_req + dram_we + pc_we
        step;
        chk("sw_done_state", 32'(state_o), 32'd0);
        chk("sw_done_cnt", inst_cnt, 32'd3);

        // ---------------- beq ----------------
        inst = I_BEQ;
        #1;
        chk("beq_c1_strobes", strobes(), 32'h30);
        step;
        chk("beq_c2_strobes", strobes(), 32'h00);
        step;
        chk("beq_c3_state", 32'(state_o), 32'd2);
        chk("beq_c3_strobes", strobes(), 32'h02);  // pc_we only
        chk("beq_npc_op", 32'(npc_op), 32'd1);
        chk("beq_alu_op", 32'(alu_op), 32'd8);
        chk("beq_sext", 32'(sext_op), 32'd4);
        step;
        chk("beq_done_state", 32'(state_o), 32'd0);
        chk("beq_done_cnt", inst_cnt, 32'd4);

        // ---------------- reset during sw MEM, dmem_ready low ----------------
        inst       = I_SW;
        dmem_ready = 1'b0;
        step;
        step;
        step;
        chk("rstmem_pre_state", 32'(state_o), 32'd3);
        chk("rstmem_pre_strobes", strobes(), 32'h0C);  // dmem_req + dram_we
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmem_async_strobes", strobes(), 32'h00);
        chk("rstmem_async_state", 32'(state_o), 32'd0);
        chk("rstmem_async_cnt", inst_cnt, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rstmem_rel_state", 32'(state_o), 32'd0);
        chk("rstmem_rel_cnt", inst_cnt, 32'd0);
        chk("rstmem_rel_hold", strobes(), 32'h00);
        step;
        chk("rstmem_refetch", strobes(), 32'h30);

        // ---------------- unknown opcode ----------------
        inst       = I_BAD;
        dmem_ready = 1'b1;
        #1;
        step;
        chk("bad_c2_state", 32'(state_o), 32'd1);
        chk("bad_c2_alu", 32'(alu_op), 32'd0);
        step;
        chk("bad_c3_strobes", strobes(), 32'h00);
`ifdef MC_ILLEGAL_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            step;
            chk("bad_halt_state", 32'(state_o), 32'd5);
            chk("bad_halt_strobes", strobes(), 32'h00);
            chk("bad_halt_cnt", inst_cnt, 32'd0);
        end
`else
        step;
        chk("bad_c4_state", 32'(state_o), 32'd4);
        chk("bad_c4_strobes", strobes(), 32'h02);  // pc_we, rf_we suppressed
        step;
        chk("bad_done_state", 32'(state_o), 32'd0);
        chk("bad_done_cnt", inst_cnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
